// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encodings, the default
// wait timeout and the access-legality check.
// No ports (package).
package mem_stage_pkg;

  // FSM states of the memory stage
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Default number of WAIT cycles tolerated without an acknowledge
  localparam int DEF_TIMEOUT = 15;

  // An access is illegal when it is both a load and a store, or when a
  // memory op targets an odd (non-word-aligned) byte address.
  function automatic logic is_illegal(input logic rd, input logic wr, input logic addr0);
    return (rd & wr) | ((rd | wr) & addr0);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register feeding the writeback stage.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears every field)
//   load_i          capture alu_result/mem_to_reg/reg_write/hlt/dst_reg
//   bubble_i        when not loading, clear reg_write and hlt (others hold)
//   mem_load_i      capture mem_data_i (load data); otherwise mem_data holds
//   *_i             field inputs
//   *_o             registered field outputs
module mem_wb_reg #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          bubble_i,
  input  logic          mem_load_i,
  input  logic [DW-1:0] alu_result_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          mem_to_reg_i,
  input  logic          reg_write_i,
  input  logic          hlt_i,
  input  logic [RW-1:0] dst_reg_i,
  output logic [DW-1:0] alu_result_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_to_reg_o,
  output logic          reg_write_o,
  output logic          hlt_o,
  output logic [RW-1:0] dst_reg_o
);

  // Field register: a bubble only kills the side-effecting bits so that the
  // remaining fields keep their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result_o <= '0;
      mem_data_o   <= '0;
      mem_to_reg_o <= 1'b0;
      reg_write_o  <= 1'b0;
      hlt_o        <= 1'b0;
      dst_reg_o    <= '0;
    end else begin
      if (load_i) begin
        alu_result_o <= alu_result_i;
        mem_to_reg_o <= mem_to_reg_i;
        reg_write_o  <= reg_write_i;
        hlt_o        <= hlt_i;
        dst_reg_o    <= dst_reg_i;
      end else if (bubble_i) begin
        reg_write_o  <= 1'b0;
        hlt_o        <= 1'b0;
      end
      if (mem_load_i) begin
        mem_data_o <= mem_data_i;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores from the EX/MEM fields to a variable
// latency memory (req/ack), stalls upstream while an access is pending and
// registers the results into the MEM/WB fields. Misaligned/illegal accesses
// and timeouts park the stage in a sticky error state until reset.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_*                       EX/MEM fields (address/ALU result, store data, controls, dst)
//   mem_req/we/addr/wdata      memory request side (combinational)
//   mem_rdata, mem_ack         memory response (ack is a one-cycle pulse)
//   stall_mem                  hold upstream pipeline this cycle
//   mem_err                    sticky error flag
//   wb_*                       registered MEM/WB fields
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW      = 16,
  parameter int RW      = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_sw_data,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_reg_write,
  input  logic          ex_hlt,
  input  logic [RW-1:0] ex_dst_reg,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_mem,
  output logic          mem_err,
  output logic [DW-1:0] wb_alu_result,
  output logic [DW-1:0] wb_mem_data,
  output logic          wb_mem_to_reg,
  output logic          wb_reg_write,
  output logic          wb_hlt,
  output logic [RW-1:0] wb_dst_reg
);

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q;

  // Copy of the in-flight instruction, so ex_* may change while we wait
  logic [DW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic          lat_we_q, lat_we_d;
  logic          lat_rd_q, lat_rd_d;
  logic          lat_m2r_q, lat_m2r_d;
  logic          lat_rw_q, lat_rw_d;
  logic          lat_hlt_q, lat_hlt_d;
  logic [RW-1:0] lat_dst_q, lat_dst_d;

  logic          mem_op_s, illegal_s;
  logic          req_s, we_s, stall_s;
  logic          wb_load_s, wb_bubble_s, wb_mem_load_s;
  logic [DW-1:0] src_alu_s;
  logic          src_m2r_s, src_rw_s, src_hlt_s;
  logic [RW-1:0] src_dst_s;

  assign mem_op_s  = ex_mem_read | ex_mem_write;
  assign illegal_s = is_illegal(ex_mem_read, ex_mem_write, ex_alu_result[0]);

  // Request-side controls are killed during reset so a pending access is dropped at once
  assign mem_req   = req_s   & rst_n;
  assign mem_we    = we_s    & rst_n;
  assign stall_mem = stall_s & rst_n;
  assign mem_err   = mem_err_q;

  // Next-state, request and writeback-control logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;
    lat_we_d      = lat_we_q;
    lat_rd_d      = lat_rd_q;
    lat_m2r_d     = lat_m2r_q;
    lat_rw_d      = lat_rw_q;
    lat_hlt_d     = lat_hlt_q;
    lat_dst_d     = lat_dst_q;
    req_s         = 1'b0;
    we_s          = 1'b0;
    stall_s       = 1'b0;
    mem_addr      = lat_addr_q;
    mem_wdata     = lat_wdata_q;
    wb_load_s     = 1'b0;
    wb_bubble_s   = 1'b0;
    wb_mem_load_s = 1'b0;
    src_alu_s     = ex_alu_result;
    src_m2r_s     = ex_mem_to_reg;
    src_rw_s      = ex_reg_write;
    src_hlt_s     = ex_hlt;
    src_dst_s     = ex_dst_reg;

    case (state_q)
      ST_IDLE: begin
        if (illegal_s) begin
          // Never issue an illegal access; freeze the pipeline in ERR
          stall_s     = 1'b1;
          wb_bubble_s = 1'b1;
          state_d     = ST_ERR;
        end else if (mem_op_s) begin
          req_s     = 1'b1;
          we_s      = ex_mem_write;
          mem_addr  = ex_alu_result;
          mem_wdata = ex_sw_data;
          if (mem_ack) begin
            wb_load_s     = 1'b1;
            wb_mem_load_s = ex_mem_read;
          end else begin
            stall_s     = 1'b1;
            wb_bubble_s = 1'b1;
            lat_addr_d  = ex_alu_result;
            lat_wdata_d = ex_sw_data;
            lat_we_d    = ex_mem_write;
            lat_rd_d    = ex_mem_read;
            lat_m2r_d   = ex_mem_to_reg;
            lat_rw_d    = ex_reg_write;
            lat_hlt_d   = ex_hlt;
            lat_dst_d   = ex_dst_reg;
            cnt_d       = '0;
            state_d     = ST_WAIT;
          end
        end else begin
          wb_load_s = 1'b1;
        end
      end
      ST_WAIT: begin
        req_s     = 1'b1;
        we_s      = lat_we_q;
        src_alu_s = lat_addr_q;
        src_m2r_s = lat_m2r_q;
        src_rw_s  = lat_rw_q;
        src_hlt_s = lat_hlt_q;
        src_dst_s = lat_dst_q;
        if (mem_ack) begin
          wb_load_s     = 1'b1;
          wb_mem_load_s = lat_rd_q;
          state_d       = ST_IDLE;
        end else begin
          stall_s     = 1'b1;
          wb_bubble_s = 1'b1;
          cnt_d       = cnt_q + CW'(1'b1);
          // counter counts completed WAIT cycles; hitting TIMEOUT means no more waiting
          if (cnt_d == TIMEOUT_C) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_ERR: begin
        stall_s     = 1'b1;
        wb_bubble_s = 1'b1;
      end
      default: begin
        wb_bubble_s = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, counter, error flag and in-flight latch registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_we_q    <= 1'b0;
      lat_rd_q    <= 1'b0;
      lat_m2r_q   <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_hlt_q   <= 1'b0;
      lat_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= (state_d == ST_ERR);
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_we_q    <= lat_we_d;
      lat_rd_q    <= lat_rd_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_rw_q    <= lat_rw_d;
      lat_hlt_q   <= lat_hlt_d;
      lat_dst_q   <= lat_dst_d;
    end
  end

  mem_wb_reg #(
    .DW(DW),
    .RW(RW)
  ) u_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (wb_load_s),
    .bubble_i     (wb_bubble_s),
    .mem_load_i   (wb_mem_load_s),
    .alu_result_i (src_alu_s),
    .mem_data_i   (mem_rdata),
    .mem_to_reg_i (src_m2r_s),
    .reg_write_i  (src_rw_s),
    .hlt_i        (src_hlt_s),
    .dst_reg_i    (src_dst_s),
    .alu_result_o (wb_alu_result),
    .mem_data_o   (wb_mem_data),
    .mem_to_reg_o (wb_mem_to_reg),
    .reg_write_o  (wb_reg_write),
    .hlt_o        (wb_hlt),
    .dst_reg_o    (wb_dst_reg)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream checked against a per-transaction reference model.
module tb_mem_stage;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] ex_alu_result, ex_sw_data;
  logic          ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_hlt;
  logic [RW-1:0] ex_dst_reg;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack, stall_mem, mem_err;
  logic [DW-1:0] wb_alu_result, wb_mem_data;
  logic          wb_mem_to_reg, wb_reg_write, wb_hlt;
  logic [RW-1:0] wb_dst_reg;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_mdata;  // model of the last load data held in MEM/WB

  mem_stage #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu_result(ex_alu_result), .ex_sw_data(ex_sw_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_hlt(ex_hlt), .ex_dst_reg(ex_dst_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_mem(stall_mem), .mem_err(mem_err),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_hlt(wb_hlt), .wb_dst_reg(wb_dst_reg)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [15:0] a, input logic [15:0] sd, input logic rd,
                        input logic wr, input logic m2r, input logic rw, input logic h,
                        input logic [3:0] dst);
    ex_alu_result = a; ex_sw_data = sd; ex_mem_read = rd; ex_mem_write = wr;
    ex_mem_to_reg = m2r; ex_reg_write = rw; ex_hlt = h; ex_dst_reg = dst;
  endtask

  task automatic set_nop();
    set_ex(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    set_ex(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
    tick(); tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req act=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we act=%b exp=0", mem_we); end
    total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL rst_stall act=%b exp=0", stall_mem); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rst_err act=%b exp=0", mem_err); end
    total++; if ({wb_alu_result, wb_mem_data, wb_mem_to_reg, wb_reg_write, wb_hlt, wb_dst_reg} !== '0) begin
      bad++; $display("FAIL rst_wb act=%h/%h/%b%b%b/%h exp=0", wb_alu_result, wb_mem_data,
                      wb_mem_to_reg, wb_reg_write, wb_hlt, wb_dst_reg); end
    set_nop();
    rst_n = 1'b1;
    exp_mdata = 16'h0000;
    tick();
  endtask

  task automatic test_alu();
    set_ex(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL alu_req act=%b exp=0", mem_req); end
    total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL alu_stall act=%b exp=0", stall_mem); end
    tick();
    total++; if (wb_alu_result !== 16'h1234) begin bad++; $display("FAIL alu_res act=%h exp=1234", wb_alu_result); end
    total++; if (wb_dst_reg !== 4'd5) begin bad++; $display("FAIL alu_dst act=%h exp=5", wb_dst_reg); end
    total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL alu_rw act=%b exp=1", wb_reg_write); end
    total++; if (wb_mem_data !== exp_mdata) begin bad++; $display("FAIL alu_mdata act=%h exp=%h", wb_mem_data, exp_mdata); end
    set_nop();
  endtask

  task automatic test_load_fast();
    set_ex(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ldf_req act=%b exp=1", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ldf_we act=%b exp=0", mem_we); end
    total++; if (mem_addr !== 16'h0040) begin bad++; $display("FAIL ldf_addr act=%h exp=0040", mem_addr); end
    total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL ldf_stall act=%b exp=0", stall_mem); end
    tick();
    mem_ack = 1'b0; exp_mdata = 16'hBEEF;
    total++; if (wb_mem_data !== 16'hBEEF) begin bad++; $display("FAIL ldf_mdata act=%h exp=BEEF", wb_mem_data); end
    total++; if (wb_mem_to_reg !== 1'b1) begin bad++; $display("FAIL ldf_m2r act=%b exp=1", wb_mem_to_reg); end
    total++; if (wb_dst_reg !== 4'd3) begin bad++; $display("FAIL ldf_dst act=%h exp=3", wb_dst_reg); end
    set_nop();
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ldf_req_after act=%b exp=0", mem_req); end
    tick();
  endtask

  task automatic test_store_slow();
    set_ex(16'h0080, 16'h55AA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) set_ex(16'hFFFF, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      mem_ack = (k == 3);
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL sts_req[%0d] act=%b exp=1", k, mem_req); end
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL sts_we[%0d] act=%b exp=1", k, mem_we); end
      total++; if (mem_addr !== 16'h0080) begin bad++; $display("FAIL sts_addr[%0d] act=%h exp=0080", k, mem_addr); end
      total++; if (mem_wdata !== 16'h55AA) begin bad++; $display("FAIL sts_wdata[%0d] act=%h exp=55AA", k, mem_wdata); end
      total++; if (stall_mem !== (k < 3)) begin bad++; $display("FAIL sts_stall[%0d] act=%b exp=%b", k, stall_mem, (k < 3)); end
      tick();
      total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL sts_rw[%0d] act=%b exp=0", k, wb_reg_write); end
      total++; if (wb_hlt !== 1'b0) begin bad++; $display("FAIL sts_hlt[%0d] act=%b exp=0", k, wb_hlt); end
    end
    mem_ack = 1'b0;
    total++; if (wb_dst_reg !== 4'd7) begin bad++; $display("FAIL sts_dst act=%h exp=7", wb_dst_reg); end
    total++; if (wb_mem_data !== exp_mdata) begin bad++; $display("FAIL sts_mdata act=%h exp=%h", wb_mem_data, exp_mdata); end
    set_nop();
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sts_req_after act=%b exp=0", mem_req); end
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin bad++;
      $display("FAIL rstp_req_stall act=%b%b exp=00", mem_req, stall_mem); end
    tick();
    rst_n = 1'b1; set_nop(); exp_mdata = 16'h0000;
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rstp_err act=%b exp=0", mem_err); end
  endtask

  task automatic test_timeout();
    set_ex(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
    mem_ack = 1'b0;
    // one IDLE issue cycle followed by TIMEOUT waiting cycles
    for (int k = 0; k <= TIMEOUT; k++) begin
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || stall_mem !== 1'b1 || mem_err !== 1'b0) begin bad++;
        $display("FAIL tmo_wait[%0d] req/stall/err act=%b%b%b exp=110", k, mem_req, stall_mem, mem_err); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (mem_err !== 1'b1 || mem_req !== 1'b0 || stall_mem !== 1'b1) begin bad++;
        $display("FAIL tmo_err[%0d] err/req/stall act=%b%b%b exp=101", k, mem_err, mem_req, stall_mem); end
      tick();
      total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL tmo_rw[%0d] act=%b exp=0", k, wb_reg_write); end
    end
    pulse_reset();
    total++; if ({wb_alu_result, wb_mem_data, wb_mem_to_reg, wb_reg_write, wb_hlt, wb_dst_reg} !== '0) begin
      bad++; $display("FAIL tmo_wb_clear act=%h/%h exp=0", wb_alu_result, wb_dst_reg); end
  endtask

  task automatic test_illegal();
    set_ex(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ill_mis_req act=%b exp=0", mem_req); end
    tick();
    @(negedge clk);
    total++; if (mem_err !== 1'b1 || mem_req !== 1'b0) begin bad++;
      $display("FAIL ill_mis err/req act=%b%b exp=10", mem_err, mem_req); end
    tick();
    pulse_reset();
    set_ex(16'h0040, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ill_rw_req act=%b exp=0", mem_req); end
    tick();
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL ill_rw_err act=%b exp=1", mem_err); end
    pulse_reset();
  endtask

  task automatic test_reset_mid_wait();
    set_ex(16'h0200, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    mem_ack = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmw_req_wait act=%b exp=1", mem_req); end
    pulse_reset();
    mem_ack = 1'b1; mem_rdata = 16'hABCD;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin bad++;
      $display("FAIL rmw_late_ack req/stall act=%b%b exp=00", mem_req, stall_mem); end
    tick();
    mem_ack = 1'b0;
    total++; if ({wb_alu_result, wb_mem_data, wb_mem_to_reg, wb_reg_write, wb_hlt, wb_dst_reg} !== '0) begin
      bad++; $display("FAIL rmw_wb act=%h/%h/%b%b%b exp=0", wb_alu_result, wb_mem_data,
                      wb_mem_to_reg, wb_reg_write, wb_hlt); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rmw_err act=%b exp=0", mem_err); end
  endtask

  // Random stream: each instruction is an ALU op, load or store with a random
  // acknowledge delay; the model predicts request, stall and MEM/WB per transaction.
  task automatic test_random(input int n);
    int op, d;
    logic [15:0] a, sd, rdat;
    logic rd, wr, rw, h;
    logic [3:0] dst;
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(2, 0));
      d = (op == 0) ? 0 : int'($urandom_range(4, 0));
      a = 16'($urandom); sd = 16'($urandom); dst = 4'($urandom);
      if (op != 0) a[0] = 1'b0;
      rd = (op == 1); wr = (op == 2);
      rw = (op == 1) ? 1'b1 : (op == 2) ? 1'b0 : 1'($urandom);
      h = ($urandom_range(7, 0) == 0);
      set_ex(a, sd, rd, wr, rd, rw, h, dst);
      if (op == 0) begin
        mem_ack = 1'($urandom); mem_rdata = 16'($urandom);  // stray ack must be ignored
        @(negedge clk);
        total++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin bad++;
          $display("FAIL rnd_alu[%0d] req/stall act=%b%b exp=00", i, mem_req, stall_mem); end
        tick();
        mem_ack = 1'b0;
        total++; if (wb_alu_result !== a || wb_reg_write !== rw || wb_hlt !== h || wb_dst_reg !== dst
                     || wb_mem_to_reg !== 1'b0 || wb_mem_data !== exp_mdata) begin bad++;
          $display("FAIL rnd_alu_wb[%0d] act=%h %b%b %h %h exp=%h %b%b %h %h", i, wb_alu_result,
                   wb_reg_write, wb_hlt, wb_dst_reg, wb_mem_data, a, rw, h, dst, exp_mdata); end
      end else begin
        for (int k = 0; k <= d; k++) begin
          if (k > 0) set_ex(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1, 4'($urandom));
          mem_ack = (k == d); rdat = 16'($urandom); mem_rdata = rdat;
          @(negedge clk);
          total++; if (mem_req !== 1'b1 || mem_we !== wr || mem_addr !== a || stall_mem !== (k != d)
                       || (wr && mem_wdata !== sd)) begin bad++;
            $display("FAIL rnd_mem[%0d.%0d] req/we/stall/addr/wd act=%b%b%b %h %h exp=1%b%b %h %h", i, k,
                     mem_req, mem_we, stall_mem, mem_addr, mem_wdata, wr, (k != d), a, sd); end
          tick();
          if (k < d) begin
            total++; if (wb_reg_write !== 1'b0 || wb_hlt !== 1'b0) begin bad++;
              $display("FAIL rnd_bubble[%0d.%0d] rw/hlt act=%b%b exp=00", i, k, wb_reg_write, wb_hlt); end
          end else begin
            if (rd) exp_mdata = rdat;
            total++; if (wb_alu_result !== a || wb_reg_write !== rw || wb_hlt !== h || wb_dst_reg !== dst
                         || wb_mem_to_reg !== rd || wb_mem_data !== exp_mdata) begin bad++;
              $display("FAIL rnd_mem_wb[%0d] act=%h %b%b%b %h %h exp=%h %b%b%b %h %h", i, wb_alu_result,
                       wb_reg_write, wb_hlt, wb_mem_to_reg, wb_dst_reg, wb_mem_data,
                       a, rw, h, rd, dst, exp_mdata); end
          end
        end
        mem_ack = 1'b0;
      end
    end
    set_nop();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_fast();
    test_store_slow();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    test_random(80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
